// File: rtl/alu_pkg.sv
// Shared ALU constants: opcodes, FSM state encoding and the data width used by the accumulator.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 12;
    localparam int unsigned ALU_OPW   = 4;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_INC  = 4'h8;
    localparam logic [3:0] OP_PASS = 4'h9;
    localparam logic [3:0] OP_MUL  = 4'hA;
    localparam logic [3:0] OP_DIV  = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_iter_core.sv
// Iterative datapath: shift-add unsigned multiply and, with ALU_DIV_EN, restoring unsigned divide.
// lo_c/hi_c present the values the registers take on the current step.
module alu_iter_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
`ifdef ALU_DIV_EN
    input  logic             mode,
`endif
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] lo_c,
    output logic [WIDTH-1:0] hi_c,
    output logic             dz
);

    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Multiply: hi accumulates, lo holds the multiplier and collects product bits.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;

    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], lo[WIDTH-1:1]};

`ifdef ALU_DIV_EN
    logic             mode_q;
    logic             dz_q;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_dif;
    logic [WIDTH:0]   div_rem;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;

    // Divide: hi is the partial remainder, lo shifts the dividend out and quotient bits in.
    assign div_sh  = {hi, lo[WIDTH-1]};
    assign div_ge  = (div_sh >= {1'b0, opnd});
    assign div_dif = div_sh - {1'b0, opnd};
    assign div_rem = div_ge ? div_dif : div_sh;
    assign div_hi  = WIDTH'(div_rem);
    assign div_lo  = {lo[WIDTH-2:0], div_ge};

    assign lo_c = mode_q ? div_lo : mul_lo;
    assign hi_c = mode_q ? div_hi : mul_hi;
    assign dz   = dz_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
            dz_q   <= 1'b0;
        end else if (load) begin
            mode_q <= mode;
            dz_q   <= mode && (b_in == '0);
        end
    end
`else
    assign lo_c = mul_lo;
    assign hi_c = mul_hi;
    assign dz   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd <= '0;
            hi   <= '0;
            lo   <= '0;
        end else if (load) begin
            opnd <= b_in;
            hi   <= '0;
            lo   <= a_in;
        end else if (step) begin
            hi   <= hi_c;
            lo   <= lo_c;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU stage feeding the accumulator: single-cycle logic/add ops, iterative MUL/DIV.
// Define ALU_DIV_EN to build the divider; otherwise opcode DIV is handled as illegal.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned OPW   = ALU_OPW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] alu_out_hi,
    output logic             busy,
    output logic             done,
    output logic             z_flag,
    output logic             c_flag,
    output logic             dz_flag
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] out_nxt, hi_nxt;
    logic             busy_nxt, done_nxt, z_nxt, c_nxt, dz_nxt;

    logic             core_load, core_step, core_dz;
    logic [WIDTH-1:0] core_lo, core_hi;
    logic             op_mul, op_div, op_iter;

    logic [WIDTH:0]   sum_ext, dif_ext, inc_ext;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c;

    assign op_mul = (op == OPW'(OP_MUL));
`ifdef ALU_DIV_EN
    assign op_div = (op == OPW'(OP_DIV));
`else
    assign op_div = 1'b0;
`endif
    assign op_iter = op_mul || op_div;

    alu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (core_load),
        .step  (core_step),
`ifdef ALU_DIV_EN
        .mode  (op_div),
`endif
        .a_in  (in1),
        .b_in  (in2),
        .lo_c  (core_lo),
        .hi_c  (core_hi),
        .dz    (core_dz)
    );

    // Single-cycle results; carry/borrow come from the WIDTH+1-bit sum/difference.
    assign sum_ext = {1'b0, in1} + {1'b0, in2};
    assign dif_ext = {1'b0, in1} - {1'b0, in2};
    assign inc_ext = {1'b0, in1} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        case (op)
            OPW'(OP_ADD):  {sc_c, sc_res} = sum_ext;
            OPW'(OP_SUB):  {sc_c, sc_res} = dif_ext;
            OPW'(OP_AND):  sc_res = in1 & in2;
            OPW'(OP_OR):   sc_res = in1 | in2;
            OPW'(OP_XOR):  sc_res = in1 ^ in2;
            OPW'(OP_NOT):  sc_res = ~in1;
            OPW'(OP_SHL):  {sc_c, sc_res} = {in1, 1'b0};
            OPW'(OP_SHR):  {sc_res, sc_c} = {1'b0, in1};
            OPW'(OP_INC):  {sc_c, sc_res} = inc_ext;
            OPW'(OP_PASS): sc_res = in2;
            default: begin
                sc_res = '0;
                sc_c   = 1'b0;
            end
        endcase
    end

    // Next-state and next-output logic; registers hold unless an op is accepted or completes.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        out_nxt   = alu_out;
        hi_nxt    = alu_out_hi;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        z_nxt     = z_flag;
        c_nxt     = c_flag;
        dz_nxt    = dz_flag;
        core_load = 1'b0;
        core_step = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                state_nxt = ST_IDLE;
                if (start) begin
                    dz_nxt = 1'b0;
                    if (op_iter) begin
                        core_load = 1'b1;
                        cnt_nxt   = '0;
                        busy_nxt  = 1'b1;
                        state_nxt = ST_ITER;
                    end else begin
                        out_nxt   = sc_res;
                        hi_nxt    = '0;
                        z_nxt     = (sc_res == '0);
                        c_nxt     = sc_c;
                        done_nxt  = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_ITER: begin
                core_step = 1'b1;
                cnt_nxt   = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    out_nxt   = core_lo;
                    hi_nxt    = core_hi;
                    z_nxt     = (core_lo == '0);
                    c_nxt     = 1'b0;
                    dz_nxt    = core_dz;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            alu_out    <= '0;
            alu_out_hi <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            z_flag     <= 1'b0;
            c_flag     <= 1'b0;
            dz_flag    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            alu_out    <= out_nxt;
            alu_out_hi <= hi_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            z_flag     <= z_nxt;
            c_flag     <= c_nxt;
            dz_flag    <= dz_nxt;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed vectors push expected results, a monitor checks each done.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'h0;
    logic [11:0] in1 = 12'h000;
    logic [11:0] in2 = 12'h000;
    logic [11:0] alu_out, alu_out_hi;
    logic        busy, done, z_flag, c_flag, dz_flag;

    alu_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .in1        (in1),
        .in2        (in2),
        .alu_out    (alu_out),
        .alu_out_hi (alu_out_hi),
        .busy       (busy),
        .done       (done),
        .z_flag     (z_flag),
        .c_flag     (c_flag),
        .dz_flag    (dz_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [11:0] out;
        logic [11:0] hi;
        logic        z;
        logic        c;
        logic        dz;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Monitor: every done pulse must match the oldest outstanding expectation, on its cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
                end else begin
                    e = sb.pop_front();
                    if ({alu_out, alu_out_hi, z_flag, c_flag, dz_flag, busy} !==
                        {e.out, e.hi, e.z, e.c, e.dz, 1'b0} || cyc != e.at) begin
                        n_bad++;
                        $display("FAIL vec%0d: got out=%h hi=%h z=%b c=%b dz=%b busy=%b cyc=%0d, required out=%h hi=%h z=%b c=%b dz=%b busy=0 cyc=%0d",
                                 e.id, alu_out, alu_out_hi, z_flag, c_flag, dz_flag, busy, cyc,
                                 e.out, e.hi, e.z, e.c, e.dz, e.at);
                    end
                end
            end
        end
    end

    // Called at a negedge; start is sampled at the following posedge.
    task automatic issue(input int id, input logic [3:0] o, input logic [11:0] a, input logic [11:0] b,
                         input logic [11:0] eo, input logic [11:0] ehi,
                         input logic ez, input logic ec, input logic edz, input int lat);
        exp_t e;
        start = 1'b1;
        op    = o;
        in1   = a;
        in2   = b;
        e = '{id: id, out: eo, hi: ehi, z: ez, c: ec, dz: edz, at: cyc + lat};
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input int id);
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain%0d: %0d results still pending after %0d cycles, required 0", id, sb.size(), k);
            sb.delete();
        end
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, got, want);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({alu_out, alu_out_hi, busy, done, z_flag, c_flag, dz_flag});
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        check("reset_state", all_outs(), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-cycle ops: id, op, in1, in2, out, hi, z, c, dz, latency
        issue(1,  OP_ADD,  12'hFFF, 12'h001, 12'h000, 12'h000, 1, 1, 0, 1);  drain(1);
        issue(2,  OP_SUB,  12'h005, 12'h007, 12'hFFE, 12'h000, 0, 1, 0, 1);  drain(2);
        issue(3,  OP_AND,  12'hA5A, 12'h0FF, 12'h05A, 12'h000, 0, 0, 0, 1);  drain(3);
        issue(4,  OP_OR,   12'h0F0, 12'h00F, 12'h0FF, 12'h000, 0, 0, 0, 1);  drain(4);
        issue(5,  OP_XOR,  12'hFFF, 12'h0F0, 12'hF0F, 12'h000, 0, 0, 0, 1);  drain(5);
        issue(6,  OP_NOT,  12'h000, 12'h123, 12'hFFF, 12'h000, 0, 0, 0, 1);  drain(6);
        issue(7,  OP_SHR,  12'h001, 12'h000, 12'h000, 12'h000, 1, 1, 0, 1);  drain(7);
        issue(8,  OP_INC,  12'hFFF, 12'h000, 12'h000, 12'h000, 1, 1, 0, 1);  drain(8);
        issue(9,  OP_PASS, 12'h456, 12'h123, 12'h123, 12'h000, 0, 0, 0, 1);  drain(9);
        issue(10, 4'hC,    12'h005, 12'h005, 12'h000, 12'h000, 1, 0, 0, 1);  drain(10);

        // MUL 0x0FF*0x011 = 0x0010EF; a start while busy and operand changes must be ignored.
        issue(11, OP_MUL, 12'h0FF, 12'h011, 12'h0EF, 12'h001, 0, 0, 0, 13);
        check("mul_busy", 64'(busy), 64'h1);
        start = 1'b1; op = OP_ADD; in1 = 12'hFFF; in2 = 12'hFFF;
        @(negedge clk);
        start = 1'b0; in1 = 12'h000; in2 = 12'h000;
        drain(11);

        issue(12, OP_MUL, 12'hFFF, 12'hFFF, 12'h001, 12'hFFE, 0, 0, 0, 13); drain(12);
        issue(13, OP_MUL, 12'h000, 12'h005, 12'h000, 12'h000, 1, 0, 0, 13); drain(13);

`ifdef ALU_DIV_EN
        issue(14, OP_DIV, 12'd100, 12'd7,   12'd14,  12'd2,   0, 0, 0, 13); drain(14);
        issue(15, OP_DIV, 12'hFFF, 12'h001, 12'hFFF, 12'h000, 0, 0, 0, 13); drain(15);
        issue(16, OP_DIV, 12'd9,   12'd0,   12'hFFF, 12'd9,   0, 0, 1, 13); drain(16);
`else
        issue(14, OP_DIV, 12'd100, 12'd7,   12'h000, 12'h000, 1, 0, 0, 1);  drain(14);
        issue(15, OP_DIV, 12'hFFF, 12'h001, 12'h000, 12'h000, 1, 0, 0, 1);  drain(15);
        issue(16, OP_DIV, 12'd9,   12'd0,   12'h000, 12'h000, 1, 0, 0, 1);  drain(16);
`endif
        // Next accepted start clears dz
        issue(17, OP_ADD, 12'h001, 12'h001, 12'h002, 12'h000, 0, 0, 0, 1);  drain(17);

        // Reset in the middle of a MUL: outputs clear at once and the MUL never completes.
        issue(18, OP_MUL, 12'h123, 12'h456, 12'h000, 12'h000, 0, 0, 0, 13);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1 check("reset_mid_mul", all_outs(), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (16) @(negedge clk);
        issue(19, OP_ADD, 12'h003, 12'h004, 12'h007, 12'h000, 0, 0, 0, 1);  drain(19);

        // Back-to-back: second start lands in the DONE cycle of the first.
        @(negedge clk);
        issue(20, OP_ADD, 12'h001, 12'h002, 12'h003, 12'h000, 0, 0, 0, 1);
        issue(21, OP_SHL, 12'h801, 12'h000, 12'h002, 12'h000, 0, 1, 0, 1);
        drain(21);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
